// File: rtl/pong_pkg.sv
// Shared constants for the Pong pixel renderer: object colours, background band
// thresholds and the hit-flash state encoding.
package pong_pkg;

    localparam logic [7:0] COL_BALL       = 8'hFF;
    localparam logic [7:0] COL_BALL_FLASH = 8'h00;
    localparam logic [7:0] COL_P1         = 8'hE0;
    localparam logic [7:0] COL_P2         = 8'h03;

    localparam int BG_X_RED   = 50;
    localparam int BG_X_GREEN = 100;
    localparam int BG_Y_B0    = 100;
    localparam int BG_Y_B1    = 200;
    localparam int BG_Y_B2    = 300;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLASH = 1'b1
    } flash_state_e;

    // Blue channel of the background: four horizontal bands, brightest at the top.
    function automatic logic [1:0] bg_blue(input int y);
        if (y < BG_Y_B0)      return 2'b11;
        else if (y < BG_Y_B1) return 2'b10;
        else if (y < BG_Y_B2) return 2'b01;
        else                  return 2'b00;
    endfunction

endpackage

// File: rtl/pong_box_hit.sv
// Half-open box membership test; the box end is formed one bit wider than the
// coordinates so an object near the top of the coordinate range does not wrap.
module pong_box_hit #(
    parameter int COORD_W = 10,
    parameter int SIZE_X  = 10,
    parameter int SIZE_Y  = 10
) (
    input  logic [COORD_W-1:0] pix_x_i,
    input  logic [COORD_W-1:0] pix_y_i,
    input  logic [COORD_W-1:0] box_x_i,
    input  logic [COORD_W-1:0] box_y_i,
    output logic               hit_o
);

    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    assign x_end = {1'b0, box_x_i} + (COORD_W+1)'(SIZE_X);
    assign y_end = {1'b0, box_y_i} + (COORD_W+1)'(SIZE_Y);

    assign hit_o = (pix_x_i >= box_x_i) && ({1'b0, pix_x_i} < x_end) &&
                   (pix_y_i >= box_y_i) && ({1'b0, pix_y_i} < y_end);

endmodule

// File: rtl/pong_pixel_renderer.sv
// Two-stage pixel renderer: per-frame shadowed object positions, box hit tests,
// priority colour mux and a frame-counted hit-flash state machine.
module pong_pixel_renderer
    import pong_pkg::*;
#(
    parameter int COORD_W      = 10,
    parameter int BALL_SIZE    = 10,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 60,
    parameter int FLASH_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_valid,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] xpixel,
    input  logic [COORD_W-1:0] ypixel,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    input  logic [COORD_W-1:0] paddle_one_x,
    input  logic [COORD_W-1:0] paddle_one_y,
    input  logic [COORD_W-1:0] paddle_two_x,
    input  logic [COORD_W-1:0] paddle_two_y,
    input  logic               hit_pulse,
    output logic [2:0]         red,
    output logic [2:0]         green,
    output logic [1:0]         blue,
    output logic               rgb_valid,
    output logic               flashing
);

    logic [COORD_W-1:0] ball_x_q, ball_y_q, p1_x_q, p1_y_q, p2_x_q, p2_y_q;
    logic               hit_ball, hit_p1, hit_p2;
    logic               in_ball_p1_q, in_p1_p1_q, in_p2_p1_q, vld_p1_q;
    logic               bg_r_p1_q, bg_g_p1_q;
    logic [1:0]         bg_b_p1_q;
    logic [7:0]         rgb_d, rgb_p2_q;
    logic               vld_p2_q;
    flash_state_e       state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ball_x_q <= '0;
            ball_y_q <= '0;
            p1_x_q   <= '0;
            p1_y_q   <= '0;
            p2_x_q   <= '0;
            p2_y_q   <= '0;
        end else if (frame_start) begin
            ball_x_q <= ball_x;
            ball_y_q <= ball_y;
            p1_x_q   <= paddle_one_x;
            p1_y_q   <= paddle_one_y;
            p2_x_q   <= paddle_two_x;
            p2_y_q   <= paddle_two_y;
        end
    end

    pong_box_hit #(.COORD_W(COORD_W), .SIZE_X(BALL_SIZE), .SIZE_Y(BALL_SIZE)) u_hit_ball (
        .pix_x_i(xpixel), .pix_y_i(ypixel), .box_x_i(ball_x_q), .box_y_i(ball_y_q), .hit_o(hit_ball)
    );
    pong_box_hit #(.COORD_W(COORD_W), .SIZE_X(PADDLE_W), .SIZE_Y(PADDLE_H)) u_hit_p1 (
        .pix_x_i(xpixel), .pix_y_i(ypixel), .box_x_i(p1_x_q), .box_y_i(p1_y_q), .hit_o(hit_p1)
    );
    pong_box_hit #(.COORD_W(COORD_W), .SIZE_X(PADDLE_W), .SIZE_Y(PADDLE_H)) u_hit_p2 (
        .pix_x_i(xpixel), .pix_y_i(ypixel), .box_x_i(p2_x_q), .box_y_i(p2_y_q), .hit_o(hit_p2)
    );

    // Stage 1: hit flags and background band selects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ball_p1_q <= 1'b0;
            in_p1_p1_q   <= 1'b0;
            in_p2_p1_q   <= 1'b0;
            bg_r_p1_q    <= 1'b0;
            bg_g_p1_q    <= 1'b0;
            bg_b_p1_q    <= 2'b00;
            vld_p1_q     <= 1'b0;
        end else begin
            in_ball_p1_q <= hit_ball;
            in_p1_p1_q   <= hit_p1;
            in_p2_p1_q   <= hit_p2;
            bg_r_p1_q    <= int'(xpixel) < BG_X_RED;
            bg_g_p1_q    <= int'(xpixel) < BG_X_GREEN;
            bg_b_p1_q    <= bg_blue(int'(ypixel));
            vld_p1_q     <= pix_valid;
        end
    end

    // Stage 2: priority colour mux
    always_comb begin
        rgb_d = 8'h00;
        if (vld_p1_q) begin
            if (in_ball_p1_q)    rgb_d = flashing ? COL_BALL_FLASH : COL_BALL;
            else if (in_p1_p1_q) rgb_d = COL_P1;
            else if (in_p2_p1_q) rgb_d = COL_P2;
            else                 rgb_d = {bg_r_p1_q ? 3'b111 : 3'b001,
                                          bg_g_p1_q ? 3'b111 : 3'b100,
                                          bg_b_p1_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_p2_q <= 8'h00;
            vld_p2_q <= 1'b0;
        end else begin
            rgb_p2_q <= rgb_d;
            vld_p2_q <= vld_p1_q;
        end
    end

    assign red       = rgb_p2_q[7:5];
    assign green     = rgb_p2_q[4:2];
    assign blue      = rgb_p2_q[1:0];
    assign rgb_valid = vld_p2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A hit always reloads the counter, so a coincident frame_start is not counted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (hit_pulse) begin
            state_d = ST_FLASH;
            cnt_d   = 8'(FLASH_FRAMES);
        end else if (state_q == ST_FLASH && frame_start) begin
            if (cnt_q == 8'd1) begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    assign flashing = (state_q == ST_FLASH);

endmodule
